// File: rtl/mux8_1_rr.sv
// Eight-channel valid/ready arbitrated mux onto one registered, channel-tagged output stream.
// Define MUX8_RR_FAIR_EN for round-robin arbitration; default build is fixed lowest-index priority.
module mux8_1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  y_valid,
  output logic [DATA_W-1:0]     y_data,
  output logic [2:0]            y_sel,
  input  logic                  y_ready
);

  logic              r_y_valid;
  logic [DATA_W-1:0] r_y_data;
  logic [2:0]        r_y_sel;

  logic              w_load;
  logic              w_any;
  logic [2:0]        w_grant;
  logic [DATA_W-1:0] w_grant_data;

  assign w_load = !r_y_valid || y_ready;
  assign w_any  = |in_valid;

`ifdef MUX8_RR_FAIR_EN
  logic [2:0] r_ptr;

  // Search starts just past the last grant, so the most recent winner is tried last.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    w_grant = 3'd0;
    found   = 1'b0;
    cand    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = r_ptr + 3'(k);
      if (!found && in_valid[cand]) begin
        w_grant = cand;
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_grant = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (in_valid[k]) w_grant = 3'(k);
    end
  end
`endif

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_grant == 3'(k)) w_grant_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  assign in_ready = (!rst && w_load && w_any) ? (8'b1 << w_grant) : 8'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_y_sel   <= 3'd0;
`ifdef MUX8_RR_FAIR_EN
      r_ptr     <= 3'd7;
`endif
    end else if (w_load) begin
      if (w_any) begin
        r_y_valid <= 1'b1;
        r_y_data  <= w_grant_data;
        r_y_sel   <= w_grant;
`ifdef MUX8_RR_FAIR_EN
        r_ptr     <= w_grant;
`endif
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;
  assign y_sel   = r_y_sel;

endmodule

// File: tb/tb_mux8_1_rr.sv
// Directed self-checking bench for mux8_1_rr; expectations follow MUX8_RR_FAIR_EN when defined.
module tb_mux8_1_rr;

`ifdef MUX8_RR_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        y_valid;
  logic [7:0]  y_data;
  logic [2:0]  y_sel;
  logic        y_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mux8_1_rr #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_sel    (y_sel),
    .y_ready  (y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic std_data();
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  initial begin
    logic [2:0] exp_sel;
    logic [7:0] held_data;
    logic [2:0] held_sel;

    rst = 1'b1; in_valid = 8'hFF; y_ready = 1'b1;
    std_data();
    #1;
    chk("rst_ready_pre", 32'(in_ready), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 32'(in_ready), 32'h0);
      chk("rst_yvalid", 32'(y_valid), 32'h0);
      chk("rst_ydata", 32'(y_data), 32'h0);
      chk("rst_ysel", 32'(y_sel), 32'h0);
    end

    // Single channel
    rst = 1'b0; in_valid = 8'b0000_1000; in_data[3*8 +: 8] = 8'hA5;
    #1;
    chk("single_ready", 32'(in_ready), 32'h08);
    tick();
    in_valid = 8'h00;
    chk("single_yvalid", 32'(y_valid), 32'h1);
    chk("single_ysel", 32'(y_sel), 32'h3);
    chk("single_ydata", 32'(y_data), 32'hA5);

    // All channels valid after a fresh reset
    rst = 1'b1; std_data();
    tick();
    rst = 1'b0; in_valid = 8'hFF; y_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_sel = FAIR ? 3'(i % 8) : 3'd0;
      #1;
      chk($sformatf("all_ready_%0d", i), 32'(in_ready), 32'(8'b1 << exp_sel));
      tick();
      chk($sformatf("all_ysel_%0d", i), 32'(y_sel), 32'(exp_sel));
      chk($sformatf("all_ydata_%0d", i), 32'(y_data), 32'(8'h10 + 8'(exp_sel)));
    end

    // Backpressure: last word is channel 0 in both builds
    y_ready = 1'b0;
    held_sel = 3'd0; held_data = 8'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'h0);
      tick();
      chk($sformatf("bp_yvalid_%0d", i), 32'(y_valid), 32'h1);
      chk($sformatf("bp_ysel_%0d", i), 32'(y_sel), 32'(held_sel));
      chk($sformatf("bp_ydata_%0d", i), 32'(y_data), 32'(held_data));
    end
    y_ready = 1'b1;
    exp_sel = FAIR ? 3'd1 : 3'd0;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'(8'b1 << exp_sel));
    tick();
    chk("bp_release_yvalid", 32'(y_valid), 32'h1);
    chk("bp_release_ysel", 32'(y_sel), 32'(exp_sel));

    // Wrap-around: grant 6, then only channels 0 and 1 request
    in_valid = 8'b0100_0000;
    #1;
    chk("wrap_ready6", 32'(in_ready), 32'h40);
    tick();
    chk("wrap_ysel6", 32'(y_sel), 32'h6);
    in_valid = 8'b0000_0011;
    #1;
    chk("wrap_ready_a", 32'(in_ready), 32'h01);
    tick();
    chk("wrap_ysel_a", 32'(y_sel), 32'h0);
    exp_sel = FAIR ? 3'd1 : 3'd0;
    #1;
    chk("wrap_ready_b", 32'(in_ready), 32'(8'b1 << exp_sel));
    tick();
    chk("wrap_ysel_b", 32'(y_sel), 32'(exp_sel));
    chk("wrap_ydata_b", 32'(y_data), 32'(8'h10 + 8'(exp_sel)));

    // Empty input with drain clears y_valid
    in_valid = 8'h00;
    #1;
    chk("idle_ready", 32'(in_ready), 32'h0);
    tick();
    chk("idle_yvalid", 32'(y_valid), 32'h0);

    // Reset mid-stall
    in_valid = 8'b0010_0000;
    tick();
    y_ready = 1'b0; in_valid = 8'h00;
    tick();
    chk("stall_yvalid", 32'(y_valid), 32'h1);
    rst = 1'b1; in_valid = 8'hFF;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0; y_ready = 1'b1;
    chk("midrst_yvalid", 32'(y_valid), 32'h0);
    #1;
    chk("midrst_first_ready", 32'(in_ready), 32'h01);
    tick();
    chk("midrst_first_ysel", 32'(y_sel), 32'h0);
    chk("midrst_first_ydata", 32'(y_data), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
